// File: rtl/router_pkt_tx_if.sv
// Host-side and router-side signals of the router packet transmitter.
// The master modport drives the host and router inputs; the slave modport is the transmitter.
interface router_pkt_tx_if #(
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          buf_full;
  logic [CW-1:0] buf_count;
  logic          start;
  logic [1:0]    start_addr;
  logic [5:0]    start_len;
  logic          tx_idle;
  logic          start_rej;
  logic          busy;
  logic          err;
  logic          packet_valid;
  logic [7:0]    data_out;
  logic          done;
  logic          pkt_err;

  modport master (
    output wr_en, wr_data, start, start_addr, start_len, busy, err,
    input  buf_full, buf_count, tx_idle, start_rej, packet_valid, data_out, done, pkt_err
  );

  modport slave (
    input  wr_en, wr_data, start, start_addr, start_len, busy, err,
    output buf_full, buf_count, tx_idle, start_rej, packet_valid, data_out, done, pkt_err
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffered payload, header/payload/parity framing,
// busy-stall handling and a post-packet error window reported with done/pkt_err.
module router_pkt_tx #(
  parameter int DEPTH   = 64,
  parameter int CHK_WIN = 4
) (
  input  logic           clk,
  input  logic           rst,
  router_pkt_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(CHK_WIN + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_CHECK   = 3'd4
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          buf_full_q;
  logic          wr_ok_s;
  logic          pop_s;
  logic [7:0]    rd_byte_s;

  state_t        state_q;
  logic [5:0]    rem_q;
  logic [7:0]    acc_q;
  logic [WW-1:0] win_q;
  logic          flag_q;
  logic          pv_q;
  logic [7:0]    data_q;
  logic          done_q;
  logic          pkt_err_q;
  logic          rej_q;
  logic          idle_q;

  assign wr_ok_s   = bus.wr_en & ~buf_full_q;
  assign rd_byte_s = mem_q[rd_ptr_q];

  // A payload byte leaves the buffer exactly when the FSM advances onto it.
  always_comb begin
    pop_s = 1'b0;
    if (!bus.busy) begin
      case (state_q)
        S_HDR:     pop_s = 1'b1;
        S_PAYLOAD: pop_s = (rem_q != 6'd0);
        default:   pop_s = 1'b0;
      endcase
    end else begin
      pop_s = 1'b0;
    end
  end

  // Occupancy after this edge's accepted write and pop.
  always_comb begin
    count_d = count_q;
    case ({wr_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Payload storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Circular buffer pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      buf_full_q <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q    <= count_d;
      buf_full_q <= (count_d == CW'(DEPTH));
    end
  end

  // Packet sequencer with registered router and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= 6'd0;
      acc_q     <= 8'h00;
      win_q     <= '0;
      flag_q    <= 1'b0;
      pv_q      <= 1'b0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      pkt_err_q <= 1'b0;
      rej_q     <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      rej_q     <= 1'b0;
      done_q    <= 1'b0;
      pkt_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          pv_q <= 1'b0;
          if (bus.start) begin
            if ((bus.start_addr == 2'd3) || (bus.start_len == 6'd0) ||
                (count_q < CW'(bus.start_len))) begin
              rej_q <= 1'b1;
            end else begin
              rem_q   <= bus.start_len;
              pv_q    <= 1'b1;
              data_q  <= {bus.start_len, bus.start_addr};
              acc_q   <= {bus.start_len, bus.start_addr};
              state_q <= S_HDR;
              idle_q  <= 1'b0;
            end
          end
        end
        S_HDR: begin
          if (!bus.busy) begin
            data_q  <= rd_byte_s;
            acc_q   <= acc_q ^ rd_byte_s;
            rem_q   <= rem_q - 6'd1;
            state_q <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!bus.busy) begin
            if (rem_q != 6'd0) begin
              data_q <= rd_byte_s;
              acc_q  <= acc_q ^ rd_byte_s;
              rem_q  <= rem_q - 6'd1;
            end else begin
              pv_q    <= 1'b0;
              data_q  <= acc_q;
              state_q <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (!bus.busy) begin
            data_q  <= 8'h00;
            win_q   <= WW'(CHK_WIN);
            flag_q  <= 1'b0;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          // The last window cycle's err still counts toward the reported flag.
          if (win_q == WW'(1)) begin
            done_q    <= 1'b1;
            pkt_err_q <= flag_q | bus.err;
            flag_q    <= 1'b0;
            state_q   <= S_IDLE;
            idle_q    <= 1'b1;
          end else begin
            flag_q <= flag_q | bus.err;
            win_q  <= win_q - WW'(1);
          end
        end
        default: begin
          pv_q    <= 1'b0;
          data_q  <= 8'h00;
          state_q <= S_IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.buf_full     = buf_full_q;
  assign bus.buf_count    = count_q;
  assign bus.tx_idle      = idle_q;
  assign bus.start_rej    = rej_q;
  assign bus.packet_valid = pv_q;
  assign bus.data_out     = data_q;
  assign bus.done         = done_q;
  assign bus.pkt_err      = pkt_err_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomized bench for router_pkt_tx against a queue-based packet model.
module tb_router_pkt_tx;
  localparam int DEPTH   = 64;
  localparam int CHK_WIN = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [7:0] model_q [$];

  router_pkt_tx_if #(.DEPTH(DEPTH)) bus ();

  router_pkt_tx #(.DEPTH(DEPTH), .CHK_WIN(CHK_WIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    bit full_before;
    full_before = (model_q.size() == DEPTH);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    if (!full_before) model_q.push_back(d);
    total++;
    if ({bus.buf_full, bus.buf_count} !== {(model_q.size() == DEPTH), 7'(model_q.size())}) begin
      bad++;
      $display("FAIL write: got full=%b count=%0d, want full=%b count=%0d",
               bus.buf_full, bus.buf_count, (model_q.size() == DEPTH), model_q.size());
    end
  endtask

  // Sends one accepted packet; stall_k/stall_n force busy while stream byte stall_k is shown.
  task automatic send_packet(input logic [1:0] addr, input logic [5:0] len, input int busy_pct,
                             input int stall_k, input int stall_n, input logic [3:0] err_mask,
                             input bit host_wr);
    logic [7:0] exp_b [$];
    logic [7:0] par;
    logic [7:0] wd;
    logic [8:0] want;
    int k, stalls, guard;
    bit b, w, full_before;
    exp_b.push_back({len, addr});
    for (int i = 0; i < int'(len); i++) exp_b.push_back(model_q[i]);
    par = 8'h00;
    foreach (exp_b[i]) par = par ^ exp_b[i];
    exp_b.push_back(par);

    bus.start = 1'b1; bus.start_addr = addr; bus.start_len = len; bus.wr_en = 1'b0;
    tick();
    bus.start = 1'b0;
    total++;
    if ({bus.packet_valid, bus.data_out, bus.tx_idle, bus.start_rej} !== {1'b1, exp_b[0], 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL header: got pv=%b data=%h idle=%b rej=%b, want pv=1 data=%h idle=0 rej=0",
               bus.packet_valid, bus.data_out, bus.tx_idle, bus.start_rej, exp_b[0]);
    end

    k = 0; stalls = 0; guard = 0;
    while (k < int'(len) + 2 && guard < 3000) begin
      guard++;
      if (k == stall_k && stalls < stall_n) begin
        b = 1'b1;
        stalls++;
      end else begin
        b = ($urandom_range(99) < busy_pct);
      end
      w  = host_wr && ($urandom_range(3) == 0);
      wd = 8'($urandom);
      full_before    = (model_q.size() == DEPTH);
      bus.busy       = b;
      bus.wr_en      = w;
      bus.wr_data    = wd;
      bus.err        = 1'($urandom);
      bus.start      = 1'($urandom);
      bus.start_addr = 2'($urandom);
      bus.start_len  = 6'($urandom);
      tick();
      if (!b) begin
        k++;
        if (k <= int'(len)) void'(model_q.pop_front());
      end
      if (w && !full_before) model_q.push_back(wd);
      if (k <= int'(len))          want = {1'b1, exp_b[k]};
      else if (k == int'(len) + 1) want = {1'b0, par};
      else                         want = 9'h000;
      total++;
      if ({bus.packet_valid, bus.data_out} !== want ||
          bus.buf_count !== 7'(model_q.size()) || bus.start_rej !== 1'b0 || bus.tx_idle !== 1'b0) begin
        bad++;
        $display("FAIL stream k=%0d busy=%b: got pv=%b data=%h count=%0d rej=%b idle=%b, want pv=%b data=%h count=%0d rej=0 idle=0",
                 k, b, bus.packet_valid, bus.data_out, bus.buf_count, bus.start_rej, bus.tx_idle,
                 want[8], want[7:0], model_q.size());
      end
    end
    bus.busy = 1'b0; bus.wr_en = 1'b0; bus.start = 1'b0;
    if (guard >= 3000) begin
      total++;
      bad++;
      $display("FAIL stream_timeout: got k=%0d, want %0d", k, int'(len) + 2);
    end

    for (int i = 0; i < CHK_WIN; i++) begin
      bus.err = err_mask[i];
      tick();
      total++;
      if ({bus.done, bus.pkt_err} !== {(i == CHK_WIN - 1), (i == CHK_WIN - 1) && (|err_mask)}) begin
        bad++;
        $display("FAIL check_win i=%0d: got done=%b pkt_err=%b, want done=%b pkt_err=%b", i,
                 bus.done, bus.pkt_err, (i == CHK_WIN - 1), (i == CHK_WIN - 1) && (|err_mask));
      end
    end
    bus.err = 1'($urandom);
    tick();
    bus.err = 1'b0;
    total++;
    if ({bus.done, bus.pkt_err, bus.tx_idle, bus.packet_valid} !== 4'b0010) begin
      bad++;
      $display("FAIL after_done: got done=%b pkt_err=%b idle=%b pv=%b, want 0 0 1 0",
               bus.done, bus.pkt_err, bus.tx_idle, bus.packet_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if ({bus.packet_valid, bus.data_out, bus.buf_count, bus.buf_full, bus.done, bus.pkt_err,
         bus.start_rej, bus.tx_idle} !== {1'b0, 8'h00, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset: got pv=%b data=%h count=%0d full=%b done=%b perr=%b rej=%b idle=%b, want 0 00 0 0 0 0 0 1",
               bus.packet_valid, bus.data_out, bus.buf_count, bus.buf_full, bus.done, bus.pkt_err,
               bus.start_rej, bus.tx_idle);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++;
    if ({bus.tx_idle, bus.packet_valid, bus.buf_count} !== {1'b1, 1'b0, 7'd0}) begin
      bad++;
      $display("FAIL post_reset: got idle=%b pv=%b count=%0d, want 1 0 0",
               bus.tx_idle, bus.packet_valid, bus.buf_count);
    end
  endtask

  task automatic test_basic();
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    send_packet(2'd1, 6'd3, 0, -1, 0, 4'b0000, 1'b0);
  endtask

  task automatic test_stall();
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    send_packet(2'd1, 6'd3, 0, 2, 3, 4'b0000, 1'b0);
  endtask

  task automatic test_reject();
    logic [1:0] ra [3];
    logic [5:0] rl [3];
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    ra = '{2'd3, 2'd0, 2'd2};
    rl = '{6'd1, 6'd0, 6'd5};
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1; bus.start_addr = ra[i]; bus.start_len = rl[i];
      tick();
      bus.start = 1'b0;
      total++;
      if ({bus.start_rej, bus.packet_valid, bus.tx_idle, bus.buf_count} !== {1'b1, 1'b0, 1'b1, 7'd3}) begin
        bad++;
        $display("FAIL reject%0d: got rej=%b pv=%b idle=%b count=%0d, want 1 0 1 3",
                 i, bus.start_rej, bus.packet_valid, bus.tx_idle, bus.buf_count);
      end
      tick();
      total++;
      if ({bus.start_rej, bus.packet_valid} !== 2'b00) begin
        bad++;
        $display("FAIL reject_pulse%0d: got rej=%b pv=%b, want 0 0", i, bus.start_rej, bus.packet_valid);
      end
    end
    send_packet(2'd2, 6'd3, 0, -1, 0, 4'b0000, 1'b0);
  endtask

  task automatic test_err();
    write_byte(8'hA5); write_byte(8'h5A);
    send_packet(2'd0, 6'd2, 0, -1, 0, 4'b0010, 1'b0);
    write_byte(8'h01);
    send_packet(2'd2, 6'd1, 0, -1, 0, 4'b0000, 1'b0);
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom));
    write_byte(8'hEE);
    send_packet(2'd1, 6'd63, 20, -1, 0, 4'b0000, 1'b0);
    total++;
    if (bus.buf_count !== 7'd1) begin
      bad++;
      $display("FAIL full_drain: got count=%0d, want 1", bus.buf_count);
    end
    for (int i = 0; i < 12; i++) write_byte(8'($urandom));
    send_packet(2'd0, 6'd13, 20, -1, 0, 4'b1000, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    for (int p = 0; p < 10; p++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) write_byte(8'($urandom));
      send_packet(2'($urandom_range(0, 2)),
                  6'($urandom_range(1, (model_q.size() > 63) ? 63 : model_q.size())),
                  30, -1, 0, 4'($urandom), 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) write_byte(8'($urandom));
    bus.start = 1'b1; bus.start_addr = 2'd1; bus.start_len = 6'd6;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    total++;
    if ({bus.packet_valid, bus.data_out, bus.buf_count, bus.tx_idle} !== {1'b0, 8'h00, 7'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid: got pv=%b data=%h count=%0d idle=%b, want 0 00 0 1",
               bus.packet_valid, bus.data_out, bus.buf_count, bus.tx_idle);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    send_packet(2'd1, 6'd3, 0, -1, 0, 4'b0000, 1'b0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; total = 0; bad = 0;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.start = 1'b0; bus.start_addr = 2'd0;
    bus.start_len = 6'd0; bus.busy = 1'b0; bus.err = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_reject();
    test_err();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
